// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx : parallel-in serial-out transmitter
//
// Accepts W-bit words over a valid/ready handshake and shifts them out one bit
// per shift_en strobe on a registered 1-bit line. A one-entry holding buffer
// lets the producer queue the next word while the current one is going out.
// When that word is queued, the next frame starts directly after the current
// one, with no idle bit between them.
//
// Parameters
//   W          word width in bits (>= 2)
//   MSB_FIRST  0: bit 0 first (a right-shift receiver rebuilds the word)
//              1: bit W-1 first
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   par_valid    in   producer presents a word on par_data
//   par_data     in   [W-1:0] word, sampled on a par_valid && par_ready edge
//   par_ready    out  transmitter can take a word this cycle (combinational)
//   shift_en     in   bit strobe; one bit leaves per enabled edge while sending
//   serial_out   out  registered serial data, holds between strobes
//   serial_valid out  registered, one cycle per emitted bit
//   frame_start  out  registered, with serial_valid on bit 0 of a frame
//   frame_done   out  registered, with serial_valid on bit W-1 of a frame
//   busy         out  high while in SEND
// -----------------------------------------------------------------------------
module piso_tx #(
  parameter int W         = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         par_valid,
  input  logic [W-1:0] par_data,
  output logic         par_ready,
  input  logic         shift_en,
  output logic         serial_out,
  output logic         serial_valid,
  output logic         frame_start,
  output logic         frame_done,
  output logic         busy
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // registered state
  state_t        r_state;
  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_hold;
  logic          r_hold_full;
  logic          r_sout;
  logic          r_svalid;
  logic          r_fstart;
  logic          r_fdone;

  // next-state values
  state_t        w_state_nxt;
  logic [W-1:0]  w_shift_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [W-1:0]  w_hold_nxt;
  logic          w_hold_full_nxt;
  logic          w_sout_nxt;
  logic          w_svalid_nxt;
  logic          w_fstart_nxt;
  logic          w_fdone_nxt;

  logic          w_accept;
  logic          w_emit;
  logic          w_last;
  logic          w_cur_bit;
  logic [W-1:0]  w_shifted;

  assign par_ready = !r_hold_full && !rst;
  assign w_accept  = par_valid && par_ready;

  assign w_emit    = (r_state == SEND) && shift_en;
  assign w_last    = w_emit && (r_cnt == CNT_LAST);

  // The outgoing bit always sits at the shift register's exit end; shifting
  // after each emit brings bit[count] there.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_cur_bit = r_shift[W-1];
      assign w_shifted = {r_shift[W-2:0], 1'b0};
    end else begin : g_lsb
      assign w_cur_bit = r_shift[0];
      assign w_shifted = {1'b0, r_shift[W-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_sout_nxt      = r_sout;
    w_svalid_nxt    = 1'b0;
    w_fstart_nxt    = 1'b0;
    w_fdone_nxt     = 1'b0;

    unique case (r_state)
      IDLE: begin
        // shift_en is ignored here; the accept edge emits nothing
        if (w_accept) begin
          w_shift_nxt = par_data;
          w_cnt_nxt   = '0;
          w_state_nxt = SEND;
        end
      end

      SEND: begin
        if (w_emit) begin
          w_sout_nxt   = w_cur_bit;
          w_svalid_nxt = 1'b1;
          w_fstart_nxt = (r_cnt == '0);
          w_fdone_nxt  = (r_cnt == CNT_LAST);
          w_shift_nxt  = w_shifted;
          w_cnt_nxt    = r_cnt + 1'b1;
        end

        if (w_last) begin
          // Reload on the last-bit edge so the next frame's bit 0 can go out
          // on the very next strobe. The hold word is older than anything on
          // par_data, so it wins; accept cannot occur while hold is full.
          w_cnt_nxt = '0;
          if (r_hold_full) begin
            w_shift_nxt     = r_hold;
            w_hold_full_nxt = 1'b0;
          end else if (w_accept) begin
            w_shift_nxt = par_data;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_accept) begin
          w_hold_nxt      = par_data;
          w_hold_full_nxt = 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sout      <= 1'b0;
      r_svalid    <= 1'b0;
      r_fstart    <= 1'b0;
      r_fdone     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_sout      <= w_sout_nxt;
      r_svalid    <= w_svalid_nxt;
      r_fstart    <= w_fstart_nxt;
      r_fdone     <= w_fdone_nxt;
    end
  end

  assign serial_out   = r_sout;
  assign serial_valid = r_svalid;
  assign frame_start  = r_fstart;
  assign frame_done   = r_fdone;
  assign busy         = (r_state == SEND);

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx : directed self-checking bench for piso_tx (W=3).
// Instance dut is LSB-first, dut_m is MSB-first. A small right-shift receiver
// model rebuilds each frame from dut's serial stream for a loopback check.
// Inputs are driven 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_piso_tx;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;

  logic         par_valid;
  logic [W-1:0] par_data;
  logic         par_ready;
  logic         shift_en;
  logic         serial_out;
  logic         serial_valid;
  logic         frame_start;
  logic         frame_done;
  logic         busy;

  logic         pv_m;
  logic [W-1:0] pd_m;
  logic         pr_m;
  logic         se_m;
  logic         so_m;
  logic         sv_m;
  logic         fs_m;
  logic         fd_m;
  logic         busy_m;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] rx_sh;
  logic [W-1:0] rx_q[$];

  always #5 clk = ~clk;

  piso_tx #(.W(W), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .par_valid(par_valid), .par_data(par_data), .par_ready(par_ready),
    .shift_en(shift_en),
    .serial_out(serial_out), .serial_valid(serial_valid),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );

  piso_tx #(.W(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst),
    .par_valid(pv_m), .par_data(pd_m), .par_ready(pr_m),
    .shift_en(se_m),
    .serial_out(so_m), .serial_valid(sv_m),
    .frame_start(fs_m), .frame_done(fd_m), .busy(busy_m)
  );

  // Right-shift receiver model: first bit received ends up in bit 0.
  always @(negedge clk) begin
    if (rst) begin
      rx_sh = '0;
    end else if (serial_valid) begin
      rx_sh = {serial_out, rx_sh[W-1:1]};
      if (frame_done) rx_q.push_back(rx_sh);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    par_valid = 1'b1;
    par_data  = 3'b111;
    shift_en  = 1'b1;
    pv_m = 1'b0; pd_m = '0; se_m = 1'b0;
    #1;
    checks++;
    if (par_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_comb: got %b expected 0", par_ready);
    end
    tick();
    tick();
    checks++;
    if ({par_ready, serial_out, serial_valid, frame_start, frame_done, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b so=%b sv=%b fs=%b fd=%b busy=%b expected all 0",
               par_ready, serial_out, serial_valid, frame_start, frame_done, busy);
    end
    rst       = 1'b0;
    par_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || serial_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_accept: got busy=%b sv=%b expected 0 0", busy, serial_valid);
    end
    checks++;
    if (par_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready: got %b expected 1", par_ready);
    end
  endtask

  task automatic test_single_frame;
    logic exp_bits [3] = '{1'b0, 1'b1, 1'b1};
    par_valid = 1'b1;
    par_data  = 3'b110;
    shift_en  = 1'b1;
    tick();
    par_valid = 1'b0;
    par_data  = 3'b000;
    checks++;
    if (busy !== 1'b1 || serial_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_accept_edge: got busy=%b sv=%b expected 1 0", busy, serial_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (serial_valid !== 1'b1 || serial_out !== exp_bits[i] ||
          frame_start !== (i == 0) || frame_done !== (i == 2)) begin
        failures++;
        $display("FAIL single_bit%0d: got sv=%b so=%b fs=%b fd=%b expected 1 %b %b %b",
                 i, serial_valid, serial_out, frame_start, frame_done,
                 exp_bits[i], (i == 0), (i == 2));
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_drop: got %b expected 0", busy);
    end
    tick();
    checks++;
    if (serial_valid !== 1'b0 || serial_out !== 1'b1) begin
      failures++;
      $display("FAIL single_idle_after: got sv=%b so=%b expected 0 1", serial_valid, serial_out);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_bits [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_rdy  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    par_valid = 1'b1;
    par_data  = 3'b101;
    shift_en  = 1'b1;
    tick();
    par_data  = 3'b011;
    for (int i = 0; i < 6; i++) begin
      tick();
      par_valid = 1'b0;
      par_data  = 3'b000;
      checks++;
      if (serial_valid !== 1'b1 || serial_out !== exp_bits[i] ||
          frame_start !== (i % 3 == 0) || frame_done !== (i % 3 == 2) ||
          par_ready !== exp_rdy[i]) begin
        failures++;
        $display("FAIL b2b_bit%0d: got sv=%b so=%b fs=%b fd=%b rdy=%b expected 1 %b %b %b %b",
                 i, serial_valid, serial_out, frame_start, frame_done, par_ready,
                 exp_bits[i], (i % 3 == 0), (i % 3 == 2), exp_rdy[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_slow_strobe;
    logic exp_bits [3] = '{1'b0, 1'b1, 1'b0};
    logic last_out;
    int   pulses;
    last_out  = 1'b0;
    pulses    = 0;
    par_valid = 1'b1;
    par_data  = 3'b010;
    shift_en  = 1'b0;
    tick();
    par_valid = 1'b0;
    par_data  = 3'b111;
    for (int k = 0; k < 9; k++) begin
      shift_en = (k % 3 == 2);
      tick();
      if (k % 3 == 2) begin
        last_out = exp_bits[pulses];
        pulses++;
      end
      checks++;
      if (serial_valid !== (k % 3 == 2) || serial_out !== last_out) begin
        failures++;
        $display("FAIL slow_cycle%0d: got sv=%b so=%b expected %b %b",
                 k, serial_valid, serial_out, (k % 3 == 2), last_out);
      end
    end
    shift_en = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL slow_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_msb_first;
    logic exp_bits [3] = '{1'b1, 1'b0, 1'b0};
    pv_m = 1'b1;
    pd_m = 3'b100;
    se_m = 1'b1;
    tick();
    pv_m = 1'b0;
    pd_m = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sv_m !== 1'b1 || so_m !== exp_bits[i] ||
          fs_m !== (i == 0) || fd_m !== (i == 2)) begin
        failures++;
        $display("FAIL msb_bit%0d: got sv=%b so=%b fs=%b fd=%b expected 1 %b %b %b",
                 i, sv_m, so_m, fs_m, fd_m, exp_bits[i], (i == 0), (i == 2));
      end
    end
    checks++;
    if (busy_m !== 1'b0) begin
      failures++;
      $display("FAIL msb_busy_end: got %b expected 0", busy_m);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic exp_bits [3] = '{1'b1, 1'b0, 1'b0};
    par_valid = 1'b1;
    par_data  = 3'b111;
    shift_en  = 1'b1;
    tick();
    par_data  = 3'b110;
    tick();
    par_valid = 1'b0;
    par_data  = 3'b000;
    checks++;
    if (par_ready !== 1'b0 || serial_out !== 1'b1) begin
      failures++;
      $display("FAIL abort_hold_full: got rdy=%b so=%b expected 0 1", par_ready, serial_out);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (par_ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready_in_rst: got %b expected 0", par_ready);
    end
    tick();
    checks++;
    if ({serial_out, serial_valid, frame_start, frame_done, busy} !== 5'b0) begin
      failures++;
      $display("FAIL abort_outputs: got so=%b sv=%b fs=%b fd=%b busy=%b expected all 0",
               serial_out, serial_valid, frame_start, frame_done, busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (par_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_hold_cleared: got rdy=%b expected 1", par_ready);
    end
    par_valid = 1'b1;
    par_data  = 3'b001;
    tick();
    par_valid = 1'b0;
    par_data  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (serial_valid !== 1'b1 || serial_out !== exp_bits[i] ||
          frame_start !== (i == 0) || frame_done !== (i == 2)) begin
        failures++;
        $display("FAIL abort_next_bit%0d: got sv=%b so=%b fs=%b fd=%b expected 1 %b %b %b",
                 i, serial_valid, serial_out, frame_start, frame_done,
                 exp_bits[i], (i == 0), (i == 2));
      end
    end
    tick();
    checks++;
    if (serial_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_stale_frame: got sv=%b busy=%b expected 0 0", serial_valid, busy);
    end
  endtask

  task automatic test_loopback;
    logic [W-1:0] exp_words [5] = '{3'b110, 3'b101, 3'b011, 3'b010, 3'b001};
    checks++;
    if (rx_q.size() !== 5) begin
      failures++;
      $display("FAIL loopback_count: got %0d frames expected 5", rx_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) begin
        checks++;
        if (rx_q[i] !== exp_words[i]) begin
          failures++;
          $display("FAIL loopback_word%0d: got %b expected %b", i, rx_q[i], exp_words[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_slow_strobe();
    test_msb_first();
    test_reset_mid_frame();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
